// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped seven-segment scan controller with per-digit enable, dots, blink,
// leading-zero blanking and a global on/off. The pins are registered from the current scan state every cycle.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 5000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clock,
  input  logic              clr_n,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [DIGITS-1:0] AN,
  output logic [7:0]        HEX
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * DIGITS;

  logic [VW-1:0]     r_value;
  logic [DIGITS-1:0] r_enable;
  logic [DIGITS-1:0] r_dots;
  logic [DIGITS-1:0] r_blink;
  logic              r_on;
  logic              r_lzb;
  logic [CW-1:0]     r_rcnt;
  logic [2:0]        r_idx;
  logic [FW-1:0]     r_frame;
  logic              r_phase;
  logic [31:0]       r_rdata;
  logic [DIGITS-1:0] r_an;
  logic [7:0]        r_hex;

  logic [31:0] w_val32;
  logic [7:0]  w_en8;
  logic [7:0]  w_dots8;
  logic [7:0]  w_blink8;
  logic [3:0]  w_nib;
  logic        w_upper_zero;
  logic        w_dark;
  logic [6:0]  w_font;
  logic [7:0]  w_an8;
  logic        w_rcnt_tc;
  logic        w_idx_wrap;
  logic [31:0] w_rd;

  // Pad per-digit state to the 8-digit maximum so a 3-bit index is always in range.
  assign w_val32      = 32'(r_value);
  assign w_en8        = 8'(r_enable);
  assign w_dots8      = 8'(r_dots);
  assign w_blink8     = 8'(r_blink);
  assign w_nib        = w_val32[{r_idx, 2'b00} +: 4];
  assign w_upper_zero = ((w_val32 >> {r_idx, 2'b00}) == 32'd0);
  assign w_an8        = ~(8'd1 << r_idx);
  assign w_rcnt_tc    = (r_rcnt == CW'(REFRESH_DIV - 1));
  assign w_idx_wrap   = w_rcnt_tc && (r_idx == 3'(DIGITS - 1));

  assign w_dark = !r_on || !w_en8[r_idx] || (w_blink8[r_idx] && r_phase) ||
                  (r_lzb && (r_idx != 3'd0) && w_upper_zero);

  always_comb begin
    w_font = 7'h7F;
    case (w_nib)
      4'h0: w_font = 7'h40;
      4'h1: w_font = 7'h79;
      4'h2: w_font = 7'h24;
      4'h3: w_font = 7'h30;
      4'h4: w_font = 7'h19;
      4'h5: w_font = 7'h12;
      4'h6: w_font = 7'h02;
      4'h7: w_font = 7'h78;
      4'h8: w_font = 7'h00;
      4'h9: w_font = 7'h10;
      4'hA: w_font = 7'h08;
      4'hB: w_font = 7'h03;
      4'hC: w_font = 7'h46;
      4'hD: w_font = 7'h21;
      4'hE: w_font = 7'h06;
      4'hF: w_font = 7'h0E;
      default: w_font = 7'h7F;
    endcase
  end

  always_comb begin
    w_rd = 32'd0;
    case (addr)
      3'd0: w_rd = w_val32;
      3'd1: w_rd = {24'd0, w_en8};
      3'd2: w_rd = {24'd0, w_dots8};
      3'd3: w_rd = {24'd0, w_blink8};
      3'd4: w_rd = {30'd0, r_lzb, r_on};
      3'd5: w_rd = {28'd0, r_phase, r_idx};
      default: w_rd = 32'd0;
    endcase
  end

  // Register file; a same-edge read returns the pre-write value.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      r_value  <= '0;
      r_enable <= '0;
      r_dots   <= '0;
      r_blink  <= '0;
      r_on     <= 1'b0;
      r_lzb    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rdata <= w_rd;
      if (we) begin
        case (addr)
          3'd0: r_value  <= wdata[VW-1:0];
          3'd1: r_enable <= wdata[DIGITS-1:0];
          3'd2: r_dots   <= wdata[DIGITS-1:0];
          3'd3: r_blink  <= wdata[DIGITS-1:0];
          3'd4: begin
            r_on  <= wdata[0];
            r_lzb <= wdata[1];
          end
          default: ;
        endcase
      end
    end
  end

  // Scan and blink timing run freely; nothing on the bus can stall them.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      r_rcnt  <= '0;
      r_idx   <= 3'd0;
      r_frame <= '0;
      r_phase <= 1'b0;
    end else begin
      if (w_rcnt_tc) begin
        r_rcnt <= '0;
        r_idx  <= w_idx_wrap ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_rcnt <= r_rcnt + CW'(1);
      end
      if (w_idx_wrap) begin
        if (r_frame == FW'(BLINK_FRAMES - 1)) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      r_an  <= '1;
      r_hex <= 8'hFF;
    end else if (w_dark) begin
      r_an  <= '1;
      r_hex <= 8'hFF;
    end else begin
      r_an  <= w_an8[DIGITS-1:0];
      r_hex <= {~w_dots8[r_idx], w_font};
    end
  end

  assign AN    = r_an;
  assign HEX   = r_hex;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl: a cycle-count reference model predicts
// pins and read data per edge, and a negedge monitor pops and compares.
module tb_seg7_scan_ctrl;

  localparam int D  = 8;
  localparam int R  = 4;
  localparam int BF = 2;

  logic        clock = 1'b0;
  logic        clr_n = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [D-1:0] an;
  logic [7:0]  hex;

  seg7_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .clr_n(clr_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .AN(an), .HEX(hex)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] exp_q[$];
  logic        model_on = 1'b0;
  int          t_model = 0;
  logic [31:0] s_value;
  logic [7:0]  s_en, s_dots, s_blink;
  logic        s_on, s_lzb;
  logic [7:0]  font [16];

  initial font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int idx_at(input int t);
    return (t / R) % D;
  endfunction

  function automatic int phase_at(input int t);
    return (t / (D * R) / BF) % 2;
  endfunction

  // Expected {AN, HEX} given the state reached after t counting cycles.
  function automatic logic [15:0] exp_pins(input int t);
    int i;
    logic [31:0] upper;
    logic dark;
    logic [7:0] an_e, hex_e;
    i     = idx_at(t);
    upper = s_value >> (4 * i);
    dark  = !s_on || !s_en[i] || (s_blink[i] && phase_at(t) == 1) ||
            (s_lzb && i != 0 && upper == 0);
    if (dark) begin
      an_e  = 8'hFF;
      hex_e = 8'hFF;
    end else begin
      an_e  = ~(8'd1 << i);
      hex_e = {~s_dots[i], font[upper[3:0]][6:0]};
    end
    return {an_e, hex_e};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a, input int t);
    case (a)
      3'd0: return s_value;
      3'd1: return {24'd0, s_en};
      3'd2: return {24'd0, s_dots};
      3'd3: return {24'd0, s_blink};
      3'd4: return {30'd0, s_lzb, s_on};
      3'd5: return 32'(idx_at(t)) | (32'(phase_at(t)) << 3);
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_model();
    s_value = 0; s_en = 0; s_dots = 0; s_blink = 0; s_on = 0; s_lzb = 0;
    t_model = 0;
  endtask

  // Reference model: one prediction per active edge, then apply this edge's write.
  always @(posedge clock) begin
    if (model_on) begin
      exp_q.push_back({exp_pins(t_model), exp_rd(addr, t_model)});
      if (we) begin
        case (addr)
          3'd0: s_value = wdata;
          3'd1: s_en    = wdata[7:0];
          3'd2: s_dots  = wdata[7:0];
          3'd3: s_blink = wdata[7:0];
          3'd4: begin s_on = wdata[0]; s_lzb = wdata[1]; end
          default: ;
        endcase
      end
      t_model++;
    end
  end

  // Monitor: outputs are valid every cycle after an edge, compared at the falling edge.
  always @(negedge clock) begin
    logic [47:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("AN", 32'(an), 32'(e[47:40]));
      chk("HEX", 32'(hex), 32'(e[39:32]));
      chk("rdata", rdata, e[31:0]);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      we = 1'b0;
      addr = 3'($urandom_range(0, 7));
      wdata = $urandom;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clock);
    we = 1'b0; addr = 3'($urandom_range(0, 7)); wdata = $urandom;
  endtask

  task automatic rd(input logic [2:0] a);
    @(negedge clock);
    we = 1'b0; addr = a;
  endtask

  // Asserts reset between edges with a write in flight, checks the pins at once, then releases.
  task automatic do_reset();
    @(posedge clock);
    #2;
    we = 1'b1; addr = 3'd0; wdata = $urandom;
    clr_n = 1'b0;
    model_on = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_AN", 32'(an), 32'h0000_00FF);
    chk("rst_HEX", 32'(hex), 32'h0000_00FF);
    chk("rst_rdata", rdata, 32'd0);
    repeat (3) @(negedge clock);
    chk("rst_hold_AN", 32'(an), 32'h0000_00FF);
    we = 1'b0;
    addr = 3'd0;
    clear_model();
    clr_n = 1'b1;
    model_on = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_model();
    do_reset();
    idle(40);

    wr(3'd0, 32'h0123_45AF);
    wr(3'd1, 32'h0000_00FF);
    wr(3'd4, 32'h0000_0001);
    idle(40);

    wr(3'd2, 32'h0000_0001);
    wr(3'd1, 32'h0000_00FE);
    idle(40);
    wr(3'd1, 32'h0000_00FF);
    idle(40);

    wr(3'd0, 32'h0000_0080);
    wr(3'd4, 32'h0000_0003);
    idle(40);
    wr(3'd0, 32'h0000_0000);
    idle(40);

    wr(3'd0, 32'h0123_45AF);
    wr(3'd3, 32'h0000_0004);
    for (int i = 0; i < 200; i++) rd(3'd5);
    idle(20);

    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1);
    rd(3'd6);
    wr(3'd7, 32'hDEAD_BEEF);
    for (int a = 0; a < 8; a++) rd(3'(a));

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) wr(3'($urandom_range(0, 7)), $urandom);
      else idle($urandom_range(1, 6));
    end

    wr(3'd0, $urandom);
    wr(3'd1, $urandom);
    wr(3'd2, $urandom);
    wr(3'd3, $urandom);
    wr(3'd4, 32'h0000_0001);
    idle(13);
    do_reset();
    idle(40);
    wr(3'd1, 32'h0000_00FF);
    wr(3'd4, 32'h0000_0001);
    idle(40);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
